// File: rtl/lsu_mem_pkg.sv
// lsu_mem_pkg: shared types and helpers for the LSU data memory path.
//   lsu_state_e : request FSM states (IDLE/BUSY/RESP)
//   nb_of       : byte-lane count for a word width
//   lane_msb    : MSB bit index of byte lane i (lane 0 is the word MSB, big-endian)
//   addr_bad    : misaligned or out-of-range check, shared with the load/store queue
package lsu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  function automatic int nb_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int lane_msb(input int data_w, input int lane);
    return data_w - 1 - 8 * lane;
  endfunction

  // Address is widened to 64 bits so addr+nb cannot wrap for any ADDR_W <= 63.
  function automatic logic addr_bad(input logic [63:0] addr, input int nb, input int depth);
    return ((addr % 64'(nb)) != 64'd0) || ((addr + 64'(nb)) > 64'(depth));
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// byte_lane_ram: DEPTH x 8 byte store with one NB-lane write port and a
// registered NB-lane read capture.
//   clk, rst_n : clock, async active-low reset (capture register only)
//   i_wr_en    : commit enabled lanes of i_wdata at i_base
//   i_cap_en   : load the capture register this edge
//   i_rd_en    : when capturing, take storage bytes; otherwise capture zeros
//   i_base     : byte address of lane 0
//   i_wdata    : write word, lane i = bits [DATA_W-1-8i -: 8]
//   i_be       : lane enables; disabled lanes are not written and read as 0
//   o_rdata    : capture register
module byte_lane_ram import lsu_mem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IW     = 6
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr_en,
  input  logic                i_cap_en,
  input  logic                i_rd_en,
  input  logic [IW-1:0]       i_base,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_be,
  output logic [DATA_W-1:0]   o_rdata
);
  localparam int NB = nb_of(DATA_W);

  logic [7:0]        r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic [IW-1:0]     w_idx [NB];

  always_comb begin
    for (int i = 0; i < NB; i++) w_idx[i] = i_base + IW'(i);
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int i = 0; i < NB; i++)
        if (i_be[i]) r_mem[w_idx[i]] <= i_wdata[lane_msb(DATA_W, i) -: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_cap_en) begin
      for (int i = 0; i < NB; i++)
        r_rdata[lane_msb(DATA_W, i) -: 8] <= (i_rd_en && i_be[i]) ? r_mem[w_idx[i]] : 8'h00;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lsu_data_ram.sv
// lsu_data_ram: byte-addressed big-endian data memory with valid/ready
// request/response handshakes, per-byte enables and fixed access latency.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : request handshake (one outstanding access)
//   req_we/addr/wdata/be  : request fields, latched on acceptance
//   resp_valid/resp_ready : response handshake, held stable under back-pressure
//   resp_rdata            : read data (zero for writes, errors, disabled lanes)
//   resp_err              : misaligned or out-of-range request
module lsu_data_ram import lsu_mem_pkg::*; #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);
  localparam int NB     = nb_of(DATA_W);
  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam int CNT_LD = (LATENCY >= 2) ? LATENCY - 2 : 0;
  localparam bit DIRECT = (LATENCY == 1);

  lsu_state_e        r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [NB-1:0]     r_be;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_err;

  logic              w_idle;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [NB-1:0]     w_be;
  logic              w_err;
  logic              w_commit;

  assign w_idle = (r_state == ST_IDLE);

  // With LATENCY==1 the commit edge is the acceptance edge, so the live
  // request fields are used instead of the (not yet loaded) latch.
  assign w_we    = w_idle ? req_we    : r_we;
  assign w_addr  = w_idle ? req_addr  : r_addr;
  assign w_wdata = w_idle ? req_wdata : r_wdata;
  assign w_be    = w_idle ? req_be    : r_be;
  assign w_err   = addr_bad(64'(w_addr), NB, DEPTH);

  // Commit on the edge that enters RESP.
  assign w_commit = (DIRECT && w_idle && req_valid) ||
                    (r_state == ST_BUSY && r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_be        <= req_be;
            r_req_ready <= 1'b0;
            if (DIRECT) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_err        <= w_err;
            end else begin
              r_state <= ST_BUSY;
              r_cnt   <= CW'(CNT_LD);
            end
          end
        end
        ST_BUSY: begin
          if (r_cnt == '0) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_err        <= w_err;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
        end
      endcase
    end
  end

  byte_lane_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IW     (IW)
  ) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_en  (w_commit && w_we && !w_err),
    .i_cap_en (w_commit),
    .i_rd_en  (!w_we && !w_err),
    .i_base   (w_addr[IW-1:0]),
    .i_wdata  (w_wdata),
    .i_be     (w_be),
    .o_rdata  (resp_rdata)
  );

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_lsu_data_ram.sv
module tb_lsu_data_ram;
  localparam int L0 = 2;
  localparam int L1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // DUT0: 32-bit, DEPTH=60, LATENCY=2
  logic        v0 = 0, we0 = 0, rr0 = 1, rdy0, rv0, er0;
  logic [31:0] a0 = 0, wd0 = 0, rd0;
  logic [3:0]  be0 = 0;
  // DUT1: 64-bit, DEPTH=64, LATENCY=1
  logic        v1 = 0, we1 = 0, rr1 = 1, rdy1, rv1, er1;
  logic [31:0] a1 = 0;
  logic [63:0] wd1 = 0, rd1;
  logic [7:0]  be1 = 0;

  lsu_data_ram #(.ADDR_W(32), .DATA_W(32), .DEPTH(60), .LATENCY(L0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_addr(a0), .req_wdata(wd0), .req_be(be0), .resp_valid(rv0),
    .resp_ready(rr0), .resp_rdata(rd0), .resp_err(er0));

  lsu_data_ram #(.ADDR_W(32), .DATA_W(64), .DEPTH(64), .LATENCY(L1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
    .req_addr(a1), .req_wdata(wd1), .req_be(be1), .resp_valid(rv1),
    .resp_ready(rr1), .resp_rdata(rd1), .resp_err(er1));

  typedef struct { logic [63:0] rd; logic err; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic we; logic [31:0] a; logic [31:0] wd; logic [3:0] be;
    logic [31:0] rd; logic err;
  } vec_t;
  vec_t tbl[14];

  logic [7:0] ref1 [64];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic we, input logic [31:0] a,
                       input logic [63:0] wd, input logic [7:0] be);
    if (d == 0) begin v0 = v; we0 = we; a0 = a; wd0 = wd[31:0]; be0 = be[3:0]; end
    else        begin v1 = v; we1 = we; a1 = a; wd1 = wd;       be1 = be;      end
  endtask

  task automatic samp(input int d, output logic rdy, output logic rv,
                      output logic [63:0] rd, output logic er);
    if (d == 0) begin rdy = rdy0; rv = rv0; rd = {32'h0, rd0}; er = er0; end
    else        begin rdy = rdy1; rv = rv1; rd = rd1;          er = er1; end
  endtask

  task automatic set_rr(input int d, input logic r);
    if (d == 0) rr0 = r; else rr1 = r;
  endtask

  // One request; called at a negedge with the DUT idle, returns at a negedge idle.
  task automatic access(input int d, input logic we, input logic [31:0] a,
                        input logic [63:0] wd, input logic [7:0] be,
                        input logic [63:0] exp_rd, input logic exp_err,
                        input int hold, input string nm);
    logic rdy, rv, er;
    logic [63:0] rd, rd_h;
    logic er_h;
    int c0;
    exp_t e;
    set_rr(d, hold == 0);
    samp(d, rdy, rv, rd, er);
    chk({nm, " req_ready idle"}, 64'(rdy), 64'd1);
    drive(d, 1'b1, we, a, wd, be);
    sb.push_back('{rd: exp_rd, err: exp_err});
    c0 = cyc;
    @(negedge clk);
    drive(d, 1'b0, 1'b0, '0, '0, '0);
    samp(d, rdy, rv, rd, er);
    while (!rv && (cyc - c0) < 20) begin
      @(negedge clk);
      samp(d, rdy, rv, rd, er);
    end
    e = sb.pop_front();
    if (!rv) begin
      checks++; failures++;
      $display("FAIL %s timeout: resp_valid never rose", nm);
      set_rr(d, 1'b1);
      return;
    end
    chk({nm, " latency"}, 64'(cyc - c0), 64'((d == 0) ? L0 : L1));
    chk({nm, " rdata"}, rd, e.rd);
    chk({nm, " err"}, 64'(er), 64'(e.err));
    rd_h = rd; er_h = er;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      samp(d, rdy, rv, rd, er);
      chk({nm, " stall valid"}, 64'(rv), 64'd1);
      chk({nm, " stall rdata"}, rd, rd_h);
      chk({nm, " stall err"}, 64'(er), 64'(er_h));
      chk({nm, " stall req_ready"}, 64'(rdy), 64'd0);
    end
    set_rr(d, 1'b1);
    @(negedge clk);
    samp(d, rdy, rv, rd, er);
    chk({nm, " release valid"}, 64'(rv), 64'd0);
    chk({nm, " release req_ready"}, 64'(rdy), 64'd1);
  endtask

  task automatic reset_chk(input string nm);
    logic rdy, rv, er;
    logic [63:0] rd;
    for (int d = 0; d < 2; d++) begin
      samp(d, rdy, rv, rd, er);
      chk({nm, " req_ready"}, 64'(rdy), 64'd1);
      chk({nm, " resp_valid"}, 64'(rv), 64'd0);
      chk({nm, " resp_rdata"}, rd, 64'd0);
      chk({nm, " resp_err"}, 64'(er), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [63:0] wd, exp;
    logic [7:0]  be;
    logic        we, err;
    int k;

    // Table: we, addr, wdata, be, expected rdata, expected err
    tbl[0]  = '{1, 32'h08, 32'hDEADBEEF, 4'b1111, 32'h0,        0};
    tbl[1]  = '{0, 32'h08, 32'h0,        4'b1111, 32'hDEADBEEF, 0};
    tbl[2]  = '{0, 32'h08, 32'h0,        4'b0001, 32'hDE000000, 0};
    tbl[3]  = '{1, 32'h08, 32'h11223344, 4'b1010, 32'h0,        0};
    tbl[4]  = '{0, 32'h08, 32'h0,        4'b1111, 32'hDE22BE44, 0};
    tbl[5]  = '{0, 32'h06, 32'h0,        4'b1111, 32'h0,        1};
    tbl[6]  = '{1, 32'h38, 32'hA5A55A5A, 4'b1111, 32'h0,        0};
    tbl[7]  = '{1, 32'h3C, 32'hFFFFFFFF, 4'b1111, 32'h0,        1};
    tbl[8]  = '{0, 32'h38, 32'h0,        4'b1111, 32'hA5A55A5A, 0};
    tbl[9]  = '{0, 32'h3C, 32'h0,        4'b1111, 32'h0,        1};
    tbl[10] = '{1, 32'h20, 32'h12345678, 4'b1111, 32'h0,        0};
    tbl[11] = '{1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0,        0};
    tbl[12] = '{0, 32'h20, 32'h0,        4'b0110, 32'h00345600, 0};
    tbl[13] = '{0, 32'h0A, 32'h0,        4'b1111, 32'h0,        1};

    // Reset values
    @(negedge clk); @(negedge clk);
    reset_chk("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++)
      access(0, tbl[i].we, tbl[i].a, {32'h0, tbl[i].wd}, {4'h0, tbl[i].be},
             {32'h0, tbl[i].rd}, tbl[i].err, 0, $sformatf("vec%0d", i));
    access(0, 1'b0, 32'h20, '0, 8'h0F, 64'h12345678, 1'b0, 0, "noop_be_kept");

    // Back-pressure: 5 stalled cycles in RESP
    access(0, 1'b1, 32'h10, 64'h01020304, 8'h0F, 64'h0, 1'b0, 0, "pre_abort_wr");
    access(0, 1'b0, 32'h08, '0, 8'h0F, 64'hDE22BE44, 1'b0, 5, "backpressure");

    // Reset while BUSY aborts the pending write
    drive(0, 1'b1, 1'b1, 32'h10, 64'hCAFEF00D, 8'h0F);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    chk("busy req_ready", 64'(rdy0), 64'd0);
    chk("busy resp_valid", 64'(rv0), 64'd0);
    rst_n = 1'b0;
    #1;
    reset_chk("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(0, 1'b0, 32'h10, '0, 8'h0F, 64'h01020304, 1'b0, 0, "after_abort");

    // DUT1: 64-bit, LATENCY=1, checked against a byte reference model
    for (int w = 0; w < 8; w++) begin
      wd = {$urandom, $urandom};
      for (int i = 0; i < 8; i++) ref1[w*8+i] = wd[63-8*i -: 8];
      access(1, 1'b1, 32'(w*8), wd, 8'hFF, 64'h0, 1'b0, 0, "w64_fill");
    end
    access(1, 1'b1, 32'h18, 64'h0011223344556677, 8'b1000_0001, 64'h0, 1'b0, 0, "w64_ends");
    ref1[8'h18] = 8'h00; ref1[8'h1F] = 8'h77;
    access(1, 1'b0, 32'h18, '0, 8'hFF,
           {8'h00, ref1[8'h19], ref1[8'h1A], ref1[8'h1B], ref1[8'h1C], ref1[8'h1D], ref1[8'h1E], 8'h77},
           1'b0, 0, "r64_ends");
    for (int n = 0; n < 40; n++) begin
      k  = $urandom_range(0, 10);
      a  = (k <= 8) ? 32'(k * 8) : 32'(8 * $urandom_range(0, 7) + $urandom_range(1, 7));
      we = 1'($urandom_range(0, 1));
      be = 8'($urandom);
      wd = {$urandom, $urandom};
      err = (a % 8 != 0) || (a + 8 > 64);
      exp = '0;
      if (!err) begin
        for (int i = 0; i < 8; i++) begin
          if (be[i]) begin
            if (we) ref1[a+i] = wd[63-8*i -: 8];
            else    exp[63-8*i -: 8] = ref1[a+i];
          end
        end
      end
      access(1, we, a, wd, be, exp, err, (n % 13 == 0) ? 2 : 0, $sformatf("rnd%0d", n));
    end

    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
